// File: rtl/siso_pkg.sv
// Shared constants and types for the serial-in serial-out delay line.
// Optional assertion block in the top is enabled by defining SISO_SVA_EN.
package siso_pkg;

   localparam int SISO_DEPTH_DEFAULT = 4;
   localparam int SISO_DEPTH_MAX     = 64;

   // Widest chain any legal build can have; a DEPTH-wide chain occupies the low bits.
   typedef logic [SISO_DEPTH_MAX-1:0] siso_chain_t;

   function automatic bit siso_depth_ok(input int depth);
      return (depth >= 1) && (depth <= SISO_DEPTH_MAX);
   endfunction

endpackage

// File: rtl/siso_stage.sv
// One stage of the delay line: a D flip-flop with synchronous active-low clear.
module siso_stage
   import siso_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!rst) q <= 1'b0;
      else      q <= d;
   end

endmodule

// File: rtl/siso_shift_reg.sv
// Serial-in serial-out shift register: s_in delayed by DEPTH clocks onto a registered s_out.
// Define SISO_SVA_EN to compile in the delay/reset assertions and output cover points.
module siso_shift_reg
   import siso_pkg::*;
#(
   parameter int DEPTH = SISO_DEPTH_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic s_in,
   output logic s_out
);

   if (!siso_depth_ok(DEPTH)) begin : g_bad_depth
      $error("siso_shift_reg: DEPTH=%0d outside 1..%0d", DEPTH, SISO_DEPTH_MAX);
   end

   logic [DEPTH-1:0] stage;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic d;
      if (g == 0) begin : g_head
         assign d = s_in;
      end else begin : g_link
         assign d = stage[g-1];
      end
      siso_stage u_stage (
         .clk (clk),
         .rst (rst),
         .d   (d),
         .q   (stage[g])
      );
   end

   assign s_out = stage[DEPTH-1];

`ifdef SISO_SVA_EN
   localparam int CW = $clog2(SISO_DEPTH_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Consecutive non-reset edges, saturating at DEPTH: the delay check is only
   // meaningful once a full window of shifts has happened without a clear.
   logic [CW-1:0] run_cnt;
   always_ff @(posedge clk) begin
      if (!rst)                 run_cnt <= '0;
      else if (run_cnt < DEPTH_C) run_cnt <= run_cnt + CW'(1);
   end

   a_delay : assert property (@(posedge clk)
      (run_cnt == DEPTH_C) |-> (s_out === $past(s_in, DEPTH)));

   a_reset_clear : assert property (@(posedge clk)
      !rst |=> (s_out == 1'b0));

   c_rise : cover property (@(posedge clk) $rose(s_out));
   c_fall : cover property (@(posedge clk) $fell(s_out));
`endif

endmodule

// File: tb/tb_siso_shift_reg.sv
// Directed bench for siso_shift_reg: a DEPTH=4 and a DEPTH=1 instance on one clock and reset.
module tb_siso_shift_reg;

   logic clk = 1'b0;
   logic rst;
   logic s_in4, s_in1;
   logic s_out4, s_out1;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   siso_shift_reg #(.DEPTH(4)) u_d4 (
      .clk   (clk),
      .rst   (rst),
      .s_in  (s_in4),
      .s_out (s_out4)
   );

   siso_shift_reg #(.DEPTH(1)) u_d1 (
      .clk   (clk),
      .rst   (rst),
      .s_in  (s_in1),
      .s_out (s_out1)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive at the falling edge, return 1ns after the next rising edge.
   task automatic step(input logic d4, input logic d1, input logic r);
      @(negedge clk);
      s_in4 = d4;
      s_in1 = d1;
      rst   = r;
      @(posedge clk);
      #1;
   endtask

   logic pin  [13] = '{1,0,1,1,1,0,0,1,1,0,0,0,0};
   logic pexp [13] = '{0,0,0,1,0,1,1,1,0,0,1,1,0};
   logic t1in [3]  = '{1,0,1};

   initial begin
      rst   = 1'b1;
      s_in4 = 1'b0;
      s_in1 = 1'b0;

      // Reset edge with s_in=1: the sampled 1 is discarded.
      step(1'b1, 1'b1, 1'b0);
      chk("reset_d4", s_out4, 1'b0);
      chk("reset_d1", s_out1, 1'b0);

      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1);
         chk($sformatf("post_reset_zero[%0d]", i), s_out4, 1'b0);
      end

      // Pattern through DEPTH=4: s_out after edge k is s_in from edge k-3.
      for (int i = 0; i < 13; i++) begin
         step(pin[i], 1'b0, 1'b1);
         chk($sformatf("pattern[%0d]", i), s_out4, pexp[i]);
      end

      // Reset mid-stream drops all bits in flight.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b1);
         chk($sformatf("load_ones[%0d]", i), s_out4, (i == 3) ? 1'b1 : 1'b0);
      end
      step(1'b1, 1'b0, 1'b0);
      chk("midstream_reset", s_out4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1);
         chk($sformatf("after_mid_reset[%0d]", i), s_out4, 1'b0);
      end
      step(1'b0, 1'b0, 1'b1);

      // A reset glitch between edges must not clear the loaded chain.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
      chk("reload_ones", s_out4, 1'b1);
      @(negedge clk);
      s_in4 = 1'b1;
      #1 rst = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("glitch_ignored", s_out4, 1'b1);

      // Constant fill: rises on the 4th sampling edge and stays high.
      step(1'b1, 1'b0, 1'b0);
      chk("fill_reset", s_out4, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b0, 1'b1);
         chk($sformatf("fill[%0d]", i), s_out4, (i >= 3) ? 1'b1 : 1'b0);
      end

      // X propagates through the chain; reset clears it.
      step(1'bx, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      chk("x_propagates", s_out4, 1'bx);
      step(1'b0, 1'b0, 1'b0);
      chk("x_cleared", s_out4, 1'b0);

      // DEPTH=1: a single flop, output follows input one edge later.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, t1in[i], 1'b1);
         chk($sformatf("depth1[%0d]", i), s_out1, t1in[i]);
      end
      step(1'b0, 1'b1, 1'b0);
      chk("depth1_reset", s_out1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
